// File: rtl/logreg_pkg.sv
// Shared Q8.8 constants and FSM encodings for the logistic-regression datapath.
// The blocks below use these in place of their own width/encoding literals.
package logreg_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned FRAC = 8;

    localparam logic [DW-1:0] ONE     = 16'h0100;
    localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DW-1:0] SAT_MIN = 16'h8000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/logreg_sat.sv
// Wide-to-Q8.8 conversion: arithmetic shift right by FRAC (truncates toward -inf),
// then clamps to the signed DW-bit range. Purely combinational.
module logreg_sat #(
    parameter int unsigned ACC_W = 36,
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [DW-1:0]    z_o
);

    logic signed [ACC_W-1:0] shifted;
    logic                    ovf;

    always_comb begin
        shifted = acc_i >>> FRAC;
        // Fits in DW bits only if every bit from DW-1 upward matches the sign.
        ovf = ~((&shifted[ACC_W-1:DW-1]) | ~(|shifted[ACC_W-1:DW-1]));
        if (!ovf) begin
            z_o = shifted[DW-1:0];
        end else if (shifted[ACC_W-1]) begin
            z_o = {1'b1, {(DW-1){1'b0}}};
        end else begin
            z_o = {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/logreg_dot_mac.sv
// Linear score stage: z = bias + sum(x_i * w_i) over N_FEAT streamed pairs,
// returned as a saturated Q8.8 value on a valid/ready output.
module logreg_dot_mac #(
    parameter int unsigned N_FEAT = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ACC_W  = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] bias,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [DW-1:0] x_data,
    input  logic [DW-1:0] w_data,
    output logic          z_valid,
    input  logic          z_ready,
    output logic [DW-1:0] z_data,
    output logic          busy
);
    import logreg_pkg::*;

    localparam int unsigned         CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(N_FEAT - 1);

    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           z_data_q, z_data_d;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [DW-1:0]           sat_z;
    logic                    beat;

    // Q8.8 * Q8.8 gives Q16.16; bias is lifted into the same scale.
    assign prod     = $signed(x_data) * $signed(w_data);
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
    assign acc_sum  = acc_q + prod_ext;

    assign x_ready = (state_q == ST_ACC);
    assign z_valid = (state_q == ST_OUT);
    assign busy    = (state_q != ST_IDLE);
    assign z_data  = z_data_q;
    assign beat    = x_valid & x_ready;

    // Score is captured from the final sum so it is already stable on entry to OUT.
    logreg_sat #(
        .ACC_W (ACC_W),
        .DW    (DW),
        .FRAC  (FRAC)
    ) u_sat (
        .acc_i (acc_sum),
        .z_o   (sat_z)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        z_data_d = z_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        z_data_d = sat_z;
                        state_d  = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (z_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            z_data_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            z_data_q <= z_data_d;
        end
    end

endmodule

// File: tb/tb_logreg_dot_mac.sv
// Directed-vector bench for logreg_dot_mac: table of vectors with hand-computed
// Q8.8 scores, plus an asynchronous reset sequence in the middle of accumulation.
module tb_logreg_dot_mac;
    import logreg_pkg::*;

    localparam int unsigned NF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [15:0] x_data = '0;
    logic [15:0] w_data = '0;
    logic        z_valid;
    logic        z_ready = 1'b0;
    logic [15:0] z_data;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    logreg_dot_mac #(
        .N_FEAT (NF),
        .DW     (16),
        .FRAC   (8),
        .ACC_W  (36)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bias    (bias),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_data  (x_data),
        .w_data  (w_data),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .z_data  (z_data),
        .busy    (busy)
    );

    // Element [0] of each packed array is the first beat.
    typedef struct {
        logic [15:0]          bias;
        logic [3:0][15:0]     xs;
        logic [3:0][15:0]     ws;
        logic [3:0][2:0]      gaps;
        int unsigned          zdly;
        bit                   noise;
        logic [15:0]          exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int unsigned cyc;
        int unsigned exp_cyc;
        string       tag;
        v       = vecs[idx];
        cyc     = 0;
        exp_cyc = 1 + NF;
        tag     = $sformatf("vec%0d", idx);

        start = 1'b1;
        bias  = v.bias;
        @(posedge clk); cyc++;
        @(negedge clk);
        start = v.noise;
        bias  = v.noise ? 16'h7F00 : 16'h0000;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);

        for (int i = 0; i < int'(NF); i++) begin
            for (int g = 0; g < int'(v.gaps[i]); g++) begin
                x_valid = 1'b0;
                x_data  = 16'h7F00;
                w_data  = 16'h7F00;
                @(posedge clk); cyc++;
                @(negedge clk);
            end
            exp_cyc += 32'(v.gaps[i]);
            x_valid = 1'b1;
            x_data  = v.xs[i];
            w_data  = v.ws[i];
            check($sformatf("%s x_ready_beat%0d", tag, i), 32'(x_ready), 32'd1);
            @(posedge clk); cyc++;
            @(negedge clk);
            x_valid = 1'b0;
            x_data  = 16'h5A5A;
            w_data  = 16'hA5A5;
        end

        check({tag, " z_valid"}, 32'(z_valid), 32'd1);
        check({tag, " z_data"}, 32'(z_data), 32'(v.exp_z));
        check({tag, " x_ready_in_out"}, 32'(x_ready), 32'd0);
        check({tag, " latency"}, cyc, exp_cyc);

        for (int d = 0; d < int'(v.zdly); d++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s z_valid_hold%0d", tag, d), 32'(z_valid), 32'd1);
            check($sformatf("%s z_data_hold%0d", tag, d), 32'(z_data), 32'(v.exp_z));
            check($sformatf("%s x_ready_hold%0d", tag, d), 32'(x_ready), 32'd0);
        end

        // With noise set, start is still high on the handshake cycle and must be ignored.
        z_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_ready = 1'b0;
        start   = 1'b0;
        bias    = 16'h0000;
        check({tag, " z_valid_after_hs"}, 32'(z_valid), 32'd0);
        check({tag, " busy_after_hs"}, 32'(busy), 32'd0);
        check({tag, " z_data_idle_hold"}, 32'(z_data), 32'(v.exp_z));
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle_stays"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // 0 basic: 4 * (1.0 * 0.5) = 2.0
        vecs[0] = '{bias: 16'h0000, xs: {4{ONE}}, ws: {4{16'h0080}},
                    gaps: '0, zdly: 0, noise: 1'b0, exp_z: 16'h0200};
        // 1 signed: 0.25 + 4 * (-1.0 * 2.0) = -7.75
        vecs[1] = '{bias: 16'h0040, xs: {4{16'hFF00}}, ws: {4{16'h0200}},
                    gaps: '0, zdly: 0, noise: 1'b0, exp_z: 16'hF840};
        // 2 positive saturation: 4 * 127^2
        vecs[2] = '{bias: 16'h0000, xs: {4{16'h7F00}}, ws: {4{16'h7F00}},
                    gaps: '0, zdly: 0, noise: 1'b0, exp_z: SAT_MAX};
        // 3 negative saturation: 4 * (-128 * 127)
        vecs[3] = '{bias: 16'h0000, xs: {4{16'h8000}}, ws: {4{16'h7F00}},
                    gaps: '0, zdly: 0, noise: 1'b0, exp_z: SAT_MIN};
        // 4 basic with gaps 0/2/5 before beats 1..3
        vecs[4] = '{bias: 16'h0000, xs: {4{ONE}}, ws: {4{16'h0080}},
                    gaps: {3'd5, 3'd2, 3'd0, 3'd0}, zdly: 0, noise: 1'b0, exp_z: 16'h0200};
        // 5 signed with z_ready held low 3 cycles
        vecs[5] = '{bias: 16'h0040, xs: {4{16'hFF00}}, ws: {4{16'h0200}},
                    gaps: '0, zdly: 3, noise: 1'b0, exp_z: 16'hF840};
        // 6 basic with start pulses throughout ACC/OUT and on the handshake
        vecs[6] = '{bias: 16'h0000, xs: {4{ONE}}, ws: {4{16'h0080}},
                    gaps: {3'd0, 3'd1, 3'd0, 3'd0}, zdly: 2, noise: 1'b1, exp_z: 16'h0200};
        // 7 mixed: 1 + 1.5*2 + (-0.5)*1 + 3*(-1) + 0 = 0.5
        vecs[7] = '{bias: ONE,
                    xs: {16'h0000, 16'h0300, 16'hFF80, 16'h0180},
                    ws: {16'h0100, 16'hFF00, 16'h0100, 16'h0200},
                    gaps: '0, zdly: 1, noise: 1'b0, exp_z: 16'h0080};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset x_ready", 32'(x_ready), 32'd0);
        check("reset z_valid", 32'(z_valid), 32'd0);
        check("reset z_data", 32'(z_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle x_ready", 32'(x_ready), 32'd0);

        for (int k = 0; k < 8; k++) begin
            run_vec(k);
        end

        // -1/256 * 1/256 = -2^-16, truncated toward -inf gives -1 LSB.
        vecs[0].xs = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[0].ws = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
        vecs[0].exp_z = 16'hFFFF;
        run_vec(0);

        // Reset in the middle of accumulation, then a clean basic vector.
        start = 1'b1;
        bias  = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x_valid = 1'b1;
            x_data  = 16'h0300;
            w_data  = 16'h0300;
            @(posedge clk);
            @(negedge clk);
        end
        x_valid = 1'b0;
        check("pre_reset busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset x_ready", 32'(x_ready), 32'd0);
        check("async_reset z_valid", 32'(z_valid), 32'd0);
        check("async_reset z_data", 32'(z_data), 32'd0);
        check("async_reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0].xs = {4{ONE}};
        vecs[0].ws = {4{16'h0080}};
        vecs[0].exp_z = 16'h0200;
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logreg_dot_mac.md
Name: logreg_dot_mac

Overview:
- Upstream stage of the logistic-regression classifier: computes the linear score z = bias + sum(x_i * w_i) over one feature vector.
- Features and weights arrive one pair per beat on a valid/ready stream.
- Produces one saturated Q8.8 score per vector on a valid/ready output.
- The downstream sigmoid/threshold stage consumes the score and produces the predicted label and done status.

Parameters:
- N_FEAT, 4: number of feature/weight pairs per vector (>=1).
- DW, 16: data width of x, w, bias and z; signed two's complement Q8.8.
- FRAC, 8: fractional bits in every DW-wide operand.
- ACC_W, 36: accumulator width; must be >= 2*DW + clog2(N_FEAT) + 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new vector; sampled only in IDLE.
- bias  in  DW  signed Q8.8 bias; sampled on the accepted start cycle.
- x_valid  in  1  x_data/w_data pair valid.
- x_ready  out  1  block accepts a pair this cycle.
- x_data  in  DW  signed Q8.8 feature.
- w_data  in  DW  signed Q8.8 weight.
- z_valid  out  1  score valid.
- z_ready  in  1  downstream accepts score.
- z_data  out  DW  signed Q8.8 saturated score.
- busy  out  1  high in ACC or OUT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, cnt=0.
  - x_ready=0, z_valid=0, z_data=0, busy=0.
  - Applies immediately, including mid-operation; the partial vector is discarded.
- States IDLE, ACC, OUT.
- IDLE:
  - x_ready=0, z_valid=0.
  - start=1 -> acc <= sign_extend(bias) << FRAC, cnt <= 0, next ACC.
- ACC:
  - x_ready=1.
  - Beat = x_valid & x_ready.
  - Each beat: acc <= acc + sign_extend(x_data*w_data), using a signed 2*DW-bit product in Q16.16; cnt <= cnt+1.
  - No beat -> acc and cnt hold; gaps of any length are allowed.
  - Beat with cnt==N_FEAT-1 -> next OUT, and x_ready drops the following cycle.
- OUT:
  - z_valid=1, x_ready=0.
  - z_data = sat(acc >>> FRAC), truncation toward -inf (no rounding).
  - Saturation: result > 0x7FFF -> 0x7FFF; result < -0x8000 -> 0x8000.
  - z_data and z_valid stay stable while z_ready=0.
  - z_valid & z_ready -> next IDLE; z_valid is low the next cycle.
- Latency:
  - z_valid rises the cycle after the last beat is accepted.
  - Minimum start-to-z_valid is N_FEAT+1 cycles.
- start is ignored outside IDLE. A start in the same cycle as the output handshake is also ignored; it must be re-asserted in IDLE.
- busy = (state != IDLE).
- z_data holds its last value in IDLE; only z_valid qualifies it.
- N_FEAT=1: a single beat moves ACC to OUT.

Decomposition:
- Package logreg_pkg: DW, FRAC, Q8.8 constants (ONE=0x0100, SAT_MAX=0x7FFF, SAT_MIN=0x8000), state encoding localparams (IDLE/ACC/OUT).
- One natural sub-module: logreg_sat. Combinational ACC_W -> DW arithmetic shift-by-FRAC with saturation. Shared with the downstream sigmoid stage.

Test Plan:
- Basic: bias=0x0000, 4 beats x=0x0100, w=0x0080 back-to-back -> z_data=0x0200, z_valid 1 cycle after 4th beat, z_ready=1 -> IDLE next cycle.
- Signed + bias: bias=0x0040, 4 beats x=0xFF00, w=0x0200 -> z_data=0xF840 (-7.75).
- Saturation: 4 beats x=0x7F00, w=0x7F00 -> 0x7FFF. Then 4 beats x=0x8000, w=0x7F00 -> 0x8000.
- Flow control:
  - x_valid gaps of 0/2/5 cycles between beats -> same result as back-to-back.
  - z_ready held low 3 cycles -> z_valid/z_data stable, x_ready=0 throughout.
  - start pulses during ACC/OUT have no effect.
- Reset mid-ACC: rst_n low after 2 beats -> all outputs 0 asynchronously. Then a full basic vector -> 0x0200, with no stale accumulation.
